// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: single-clock FIFO with programmable almost-full/almost-empty
// thresholds and a selectable read mode (registered read or first-word-fall-through).
// Optional sticky overflow/underflow flags are built when SYNC_FIFO_ERR_FLAGS_EN is defined.
//
// Handshake: a write is taken on a rising edge when wr_en && !full; a read is
// taken when rd_en && !empty. A rejected request changes no state. Flags and
// count describe the state after the last edge and never depend on inputs.
module sync_fifo_prog #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         din,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  input  logic                     err_clr,
  output logic                     overflow,
  output logic                     underflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AF_T = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_T = PW'(AE_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  // The MSB of each pointer is a lap bit: equal pointers mean empty,
  // same slot on different laps means full.
  assign empty        = (rd_ptr == wr_ptr);
  assign full         = (rd_ptr[AW] != wr_ptr[AW]) && (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]);
  assign almost_full  = (count >= AF_T);
  assign almost_empty = (count <= AE_T);

  // Simultaneous requests resolve naturally: at full only the read is
  // accepted, at empty only the write (no bypass of an empty FIFO).
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  // Storage write; the array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + PW'(1);
        2'b01:   count <= count - PW'(1);
        default: count <= count;
      endcase
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is visible whenever the FIFO holds data; zero while empty.
      assign dout       = empty ? '0 : mem[rd_ptr[AW-1:0]];
      assign dout_valid = !empty;
    end else begin : g_reg
      // Registered read: the popped word appears one cycle after the accepted read.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dout       <= '0;
          dout_valid <= 1'b0;
        end else begin
          dout_valid <= rd_ok;
          if (rd_ok) dout <= mem[rd_ptr[AW-1:0]];
        end
      end
    end
  endgenerate

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  // Sticky error flags; a new error in the same cycle beats err_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full)  overflow <= 1'b1;
      else if (err_clr)   overflow <= 1'b0;
      if (rd_en && empty) underflow <= 1'b1;
      else if (err_clr)   underflow <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Testbench for sync_fifo_prog (WIDTH=16, DEPTH=8, AF=6, AE=2).
// Instance dut0 uses registered read, dut1 uses first-word-fall-through.
module tb_sync_fifo_prog;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        wr_en, rd_en;
  logic [15:0] din, dout;
  logic        dout_valid, full, empty, almost_full, almost_empty;
  logic [3:0]  count;

  logic        wr_f, rd_f;
  logic [15:0] din_f, dout_f;
  logic        dv_f, full_f, empty_f, af_f, ae_f;
  logic [3:0]  count_f;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic err_clr, overflow, underflow;
  logic err_clr_f, overflow_f, underflow_f;
`endif

  sync_fifo_prog #(.WIDTH(16), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(dout),
    .dout_valid(dout_valid), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    , .err_clr(err_clr), .overflow(overflow), .underflow(underflow)
`endif
  );

  sync_fifo_prog #(.WIDTH(16), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_f), .din(din_f), .rd_en(rd_f), .dout(dout_f),
    .dout_valid(dv_f), .full(full_f), .empty(empty_f), .almost_full(af_f),
    .almost_empty(ae_f), .count(count_f)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    , .err_clr(err_clr_f), .overflow(overflow_f), .underflow(underflow_f)
`endif
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: inputs were set before the call, outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        r;
    logic        w;
    logic        rd;
    logic [15:0] din;
    logic [3:0]  cnt;
    logic        dv;
    logic [15:0] dout;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic w, input logic rd, input logic [15:0] d,
                              input int c, input logic dv, input logic [15:0] q);
    vec_t v;
    v.r = r; v.w = w; v.rd = rd; v.din = d; v.cnt = 4'(c); v.dv = dv; v.dout = q;
    vecs.push_back(v);
  endfunction

  task automatic chk_flags0(input string tag, input int c);
    chk({tag, " count"}, 32'(count), 32'(c));
    chk({tag, " full"}, 32'(full), 32'(c == 8));
    chk({tag, " empty"}, 32'(empty), 32'(c == 0));
    chk({tag, " almost_full"}, 32'(almost_full), 32'(c >= 6));
    chk({tag, " almost_empty"}, 32'(almost_empty), 32'(c <= 2));
  endtask

  initial begin
    rst = 1'b1; wr_en = 0; rd_en = 0; din = '0;
    wr_f = 0; rd_f = 0; din_f = '0;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    err_clr = 0; err_clr_f = 0;
`endif
    step(); step();

    // Reset state of both instances
    chk_flags0("reset", 0);
    chk("reset dout", 32'(dout), 32'h0);
    chk("reset dout_valid", 32'(dout_valid), 32'h0);
    chk("reset fwft dout_valid", 32'(dv_f), 32'h0);
    chk("reset fwft empty", 32'(empty_f), 32'h1);
    rst = 1'b0;

    // Fill 1..8, overfill, simultaneous at full
    for (int k = 1; k <= 8; k++) add(0, 1, 0, 16'(k), k, 0, 16'h0);
    add(0, 1, 0, 16'h0009, 8, 0, 16'h0);
    add(0, 1, 1, 16'h00FF, 7, 1, 16'h0001);
    // Drain the rest, then read when empty
    for (int k = 2; k <= 8; k++) add(0, 0, 1, 16'h0, 8 - k, 1, 16'(k));
    add(0, 0, 1, 16'h0, 0, 0, 16'h0008);
    // Simultaneous at empty: write only, no bypass
    add(0, 1, 1, 16'h0055, 1, 0, 16'h0008);
    add(0, 0, 1, 16'h0, 0, 1, 16'h0055);
    // Reset, then wrap sequence: 5 writes, 5 reads, 6 writes, 6 reads
    add(1, 0, 0, 16'h0, 0, 0, 16'h0);
    for (int k = 0; k < 5; k++) add(0, 1, 0, 16'h0010 + 16'(k), k + 1, 0, 16'h0);
    for (int k = 0; k < 5; k++) add(0, 0, 1, 16'h0, 4 - k, 1, 16'h0010 + 16'(k));
    for (int k = 0; k < 6; k++) add(0, 1, 0, 16'h00A0 + 16'(k), k + 1, 0, 16'h0014);
    for (int k = 0; k < 6; k++) add(0, 0, 1, 16'h0, 5 - k, 1, 16'h00A0 + 16'(k));

    foreach (vecs[i]) begin
      rst = vecs[i].r; wr_en = vecs[i].w; rd_en = vecs[i].rd; din = vecs[i].din;
      step();
      chk_flags0($sformatf("v%0d", i), int'(vecs[i].cnt));
      chk($sformatf("v%0d dout_valid", i), 32'(dout_valid), 32'(vecs[i].dv));
      chk($sformatf("v%0d dout", i), 32'(dout), 32'(vecs[i].dout));
    end
    wr_en = 0; rd_en = 0; rst = 0;

    // 11 writes and 11 reads since reset: both pointers are on their second lap at slot 3
    chk("wrap wr_ptr", 32'(dut0.wr_ptr), 32'hB);
    chk("wrap rd_ptr", 32'(dut0.rd_ptr), 32'hB);

    // Asynchronous reset between edges at count=5
    for (int k = 0; k < 6; k++) begin
      wr_en = 1; din = 16'h0300 + 16'(k);
      step();
    end
    wr_en = 0; rd_en = 1;
    step();
    rd_en = 0;
    chk("pre-reset count", 32'(count), 32'd5);
    chk("pre-reset dout_valid", 32'(dout_valid), 32'h1);
    chk("pre-reset dout", 32'(dout), 32'h0300);
    #2 rst = 1'b1;
    #1;
    chk("async reset count", 32'(count), 32'd0);
    chk("async reset empty", 32'(empty), 32'h1);
    chk("async reset dout_valid", 32'(dout_valid), 32'h0);
    chk("async reset dout", 32'(dout), 32'h0);
    chk("async reset almost_empty", 32'(almost_empty), 32'h1);
    #1 rst = 1'b0;
    // First edge after release accepts a write
    wr_en = 1; din = 16'h0777;
    step();
    wr_en = 0; rd_en = 1;
    step();
    rd_en = 0;
    chk("post-reset read dout", 32'(dout), 32'h0777);
    chk("post-reset count", 32'(count), 32'd0);

    // First-word-fall-through instance
    wr_f = 1; din_f = 16'h1234;
    step();
    wr_f = 0;
    chk("fwft dout", 32'(dout_f), 32'h1234);
    chk("fwft dout_valid", 32'(dv_f), 32'h1);
    chk("fwft count", 32'(count_f), 32'd1);
    step();
    chk("fwft hold dout", 32'(dout_f), 32'h1234);
    rd_f = 1;
    step();
    rd_f = 0;
    chk("fwft read empty", 32'(empty_f), 32'h1);
    chk("fwft read dout_valid", 32'(dv_f), 32'h0);
    wr_f = 1; din_f = 16'hBEEF;
    step();
    din_f = 16'hCAFE;
    step();
    wr_f = 0;
    chk("fwft head", 32'(dout_f), 32'hBEEF);
    rd_f = 1;
    step();
    rd_f = 0;
    chk("fwft next", 32'(dout_f), 32'hCAFE);
    chk("fwft next count", 32'(count_f), 32'd1);

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    // Sticky error flags on the registered-read instance
    rst = 1; step(); rst = 0;
    rd_en = 1; step(); rd_en = 0;
    chk("underflow set", 32'(underflow), 32'h1);
    err_clr = 1; step(); err_clr = 0;
    chk("underflow clr", 32'(underflow), 32'h0);
    for (int k = 0; k < 8; k++) begin
      wr_en = 1; din = 16'(k); step();
    end
    chk("overflow before", 32'(overflow), 32'h0);
    step();
    wr_en = 0;
    chk("overflow set", 32'(overflow), 32'h1);
    step();
    chk("overflow sticky", 32'(overflow), 32'h1);
    wr_en = 1; err_clr = 1; step();
    chk("overflow set beats clr", 32'(overflow), 32'h1);
    wr_en = 0; step(); err_clr = 0;
    chk("overflow clr", 32'(overflow), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
